// File: rtl/uart_pkg.sv
// Shared UART constants and frame-field helpers for uart_rx and uart_tx.
package uart_pkg;

  localparam int unsigned BAUD_END   = 5208;
  localparam int unsigned BAUD_MID   = BAUD_END / 2 - 1;
  localparam int unsigned BIT_END    = 10;
  localparam int unsigned BAUD_CNT_W = 13;
  localparam int unsigned BIT_CNT_W  = 4;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    FIELD_START,
    FIELD_DATA,
    FIELD_STOP
  } field_e;

  // Classifies a bit index within the frame; last_idx is the stop-bit index.
  function automatic field_e field_of(input logic [BIT_CNT_W-1:0] idx,
                                      input int unsigned last_idx);
    field_e f;
    if (idx == '0)
      f = FIELD_START;
    else if (idx == BIT_CNT_W'(last_idx))
      f = FIELD_STOP;
    else
      f = FIELD_DATA;
    return f;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line in, received byte and status strobes out.
interface uart_rx_if;

  logic       rs232_rx;
  logic [7:0] rx_data;
  logic       rx_flag;
  logic       frame_err;
  logic       busy;

  modport master (
    output rs232_rx,
    input  rx_data,
    input  rx_flag,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  rs232_rx,
    output rx_data,
    output rx_flag,
    output frame_err,
    output busy
  );

endinterface

// File: rtl/uart_rx_sync_3ff.sv
// Three-flop synchroniser for the serial line with falling-edge detect.
module sync_3ff (
  input  logic sclk,
  input  logic s_rst,
  input  logic i_rx,
  output logic o_rx_sync,
  output logic o_rx_fall
);

  logic r_rx1;
  logic r_rx2;
  logic r_rx3;

  // Reset to idle-high so no spurious start is seen on an idle line.
  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      r_rx1 <= 1'b1;
      r_rx2 <= 1'b1;
      r_rx3 <= 1'b1;
    end else begin
      r_rx1 <= i_rx;
      r_rx2 <= r_rx1;
      r_rx3 <= r_rx2;
    end
  end

  assign o_rx_sync = r_rx2;
  assign o_rx_fall = r_rx3 & ~r_rx2;

endmodule

// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver: rebuilds bytes, strobes good ones, flags framing errors.
import uart_pkg::*;

module uart_rx #(
  parameter int unsigned BAUD_END = uart_pkg::BAUD_END,
  parameter int unsigned BAUD_MID = BAUD_END / 2 - 1,
  parameter int unsigned BIT_END  = uart_pkg::BIT_END
) (
  input  logic      sclk,
  input  logic      s_rst,
  uart_rx_if.slave  bus
);

  logic                  w_rx_sync;
  logic                  w_rx_fall;
  logic                  w_bit_flag;
  field_e                w_field;

  logic                  r_work_en;
  logic [BAUD_CNT_W-1:0] r_baud_cnt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [7:0]            r_shift_reg;
  logic [7:0]            r_rx_data;
  logic                  r_rx_flag;
  logic                  r_frame_err;

  sync_3ff u_sync (
    .sclk      (sclk),
    .s_rst     (s_rst),
    .i_rx      (bus.rs232_rx),
    .o_rx_sync (w_rx_sync),
    .o_rx_fall (w_rx_fall)
  );

  assign w_bit_flag = r_work_en && (r_baud_cnt == BAUD_CNT_W'(BAUD_MID));
  assign w_field    = field_of(r_bit_cnt, BIT_END - 1);

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      r_work_en   <= 1'b0;
      r_baud_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift_reg <= '0;
      r_rx_data   <= '0;
      r_rx_flag   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_flag   <= 1'b0;
      r_frame_err <= 1'b0;
      if (!r_work_en) begin
        r_baud_cnt <= '0;
        r_bit_cnt  <= '0;
        if (w_rx_fall)
          r_work_en <= 1'b1;
      end else begin
        if (r_baud_cnt == BAUD_CNT_W'(BAUD_END - 1))
          r_baud_cnt <= '0;
        else
          r_baud_cnt <= r_baud_cnt + 1'b1;

        if (w_bit_flag) begin
          r_bit_cnt <= (w_field == FIELD_STOP) ? '0 : r_bit_cnt + 1'b1;
          case (w_field)
            FIELD_START: begin
              if (w_rx_sync != START_BIT)
                r_work_en <= 1'b0;
            end
            FIELD_DATA: begin
              r_shift_reg[3'(r_bit_cnt - 1'b1)] <= w_rx_sync;
            end
            FIELD_STOP: begin
              // Dropping work_en at mid-stop lets a back-to-back start edge be caught.
              r_work_en <= 1'b0;
              if (w_rx_sync == STOP_BIT) begin
                r_rx_data <= r_shift_reg;
                r_rx_flag <= 1'b1;
              end else begin
                r_frame_err <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.rx_data   = r_rx_data;
  assign bus.rx_flag   = r_rx_flag;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = r_work_en;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a frame-timeline model checked every cycle.
module tb_uart_rx;

  localparam int unsigned BE = 16;
  localparam int unsigned BM = 7;
  // Start seen at +3 (2-flop sync + detect edge); stop sampled 9 bits + BM later.
  localparam int unsigned BUSY_OFS = 3;
  localparam int unsigned EV_OFS   = BUSY_OFS + 9 * BE + BM + 1;

  typedef struct {
    int unsigned busy_from;
    int unsigned busy_to;
    int unsigned ev_cyc;
    bit          has_ev;
    bit          good;
    logic [7:0]  data;
  } exp_t;

  logic        sclk = 1'b0;
  logic        s_rst;
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  exp_t        q[$];
  logic [7:0]  m_data = '0;
  int unsigned flag_cnt = 0;
  int unsigned err_cnt = 0;
  int unsigned last_flag_cyc = 0;
  int unsigned prev_flag_cyc = 0;
  int unsigned run = 0;
  int unsigned last_run = 0;

  uart_rx_if bus ();

  uart_rx #(.BAUD_END(BE), .BAUD_MID(BM)) dut (
    .sclk  (sclk),
    .s_rst (s_rst),
    .bus   (bus)
  );

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge sclk) begin
    logic e_busy, e_flag, e_err;
    e_busy = 1'b0;
    e_flag = 1'b0;
    e_err  = 1'b0;
    if (s_rst) begin
      q.delete();
      m_data = '0;
    end else begin
      foreach (q[i]) begin
        if (cyc >= q[i].busy_from && cyc <= q[i].busy_to)
          e_busy = 1'b1;
        if (q[i].has_ev && q[i].ev_cyc == cyc) begin
          if (q[i].good) begin
            e_flag = 1'b1;
            m_data = q[i].data;
          end else begin
            e_err = 1'b1;
          end
        end
      end
      while (q.size() > 0 && q[0].busy_to < cyc && q[0].ev_cyc < cyc)
        void'(q.pop_front());
    end
    chk("cycle", {21'b0, bus.busy, bus.frame_err, bus.rx_flag, bus.rx_data},
                 {21'b0, e_busy, e_err, e_flag, m_data});
    if (bus.rx_flag) begin
      flag_cnt++;
      prev_flag_cyc = last_flag_cyc;
      last_flag_cyc = cyc;
    end
    if (bus.frame_err)
      err_cnt++;
    if (bus.busy) begin
      run++;
    end else if (run != 0) begin
      last_run = run;
      run = 0;
    end
  end

  function automatic int unsigned bound(input int unsigned k, input int unsigned pm);
    return (k * BE * pm + 500) / 1000;
  endfunction

  // Entered and left at posedge+1; pm is bit period in per-mille of nominal.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int unsigned pm, input int unsigned nbits);
    logic [9:0]  fr;
    int unsigned c;
    fr = {stop, d, 1'b0};
    c  = cyc;
    q.push_back('{c + BUSY_OFS, c + EV_OFS - 1, c + EV_OFS, 1'b1, stop, d});
    for (int i = 0; i < int'(nbits); i++) begin
      bus.rs232_rx = fr[i];
      repeat (bound(i + 1, pm) - bound(i, pm)) @(posedge sclk);
      #1;
    end
  endtask

  task automatic idle(input int unsigned n);
    bus.rs232_rx = 1'b1;
    repeat (n) @(posedge sclk);
    #1;
  endtask

  initial begin
    int unsigned c;
    s_rst = 1'b1;
    bus.rs232_rx = 1'b1;
    repeat (3) @(posedge sclk);
    #1;
    chk("reset_state", {21'b0, bus.busy, bus.frame_err, bus.rx_flag, bus.rx_data}, 32'h0);
    s_rst = 1'b0;
    idle(10);

    send_frame(8'hA5, 1'b1, 1000, 10);
    idle(20);
    chk("t1_flags", flag_cnt, 1);
    chk("t1_errs", err_cnt, 0);
    chk("t1_data", bus.rx_data, 8'hA5);
    chk("t1_busy", bus.busy, 0);

    send_frame(8'h3C, 1'b0, 1000, 10);
    idle(20);
    chk("t4_errs", err_cnt, 1);
    chk("t4_flags", flag_cnt, 1);
    chk("t4_data_kept", bus.rx_data, 8'hA5);

    send_frame(8'h00, 1'b1, 1000, 10);
    send_frame(8'hFF, 1'b1, 1000, 10);
    idle(20);
    chk("t2_flags", flag_cnt, 3);
    chk("t2_spacing", last_flag_cyc - prev_flag_cyc, 160);
    chk("t2_data", bus.rx_data, 8'hFF);

    c = cyc;
    q.push_back('{c + BUSY_OFS, c + BUSY_OFS + BM, c + BUSY_OFS + BM, 1'b0, 1'b0, 8'h00});
    bus.rs232_rx = 1'b0;
    repeat (4) @(posedge sclk);
    #1;
    idle(30);
    chk("t3_busy_len", last_run, 8);
    chk("t3_flags", flag_cnt, 3);
    chk("t3_errs", err_cnt, 1);

    send_frame(8'h5A, 1'b1, 1000, 5);
    bus.rs232_rx = 1'b1;
    s_rst = 1'b1;
    #1;
    chk("t5_rst_data", bus.rx_data, 8'h00);
    chk("t5_rst_busy", bus.busy, 0);
    chk("t5_rst_strobes", {bus.rx_flag, bus.frame_err}, 0);
    repeat (3) @(posedge sclk);
    #1;
    s_rst = 1'b0;
    idle(10);
    send_frame(8'h81, 1'b1, 1000, 10);
    idle(20);
    chk("t5_flags", flag_cnt, 4);
    chk("t5_data", bus.rx_data, 8'h81);

    send_frame(8'hC3, 1'b1, 1040, 10);
    idle(20);
    chk("t6_slow_flags", flag_cnt, 5);
    chk("t6_slow_data", bus.rx_data, 8'hC3);
    send_frame(8'hC3, 1'b1, 960, 10);
    idle(20);
    chk("t6_fast_flags", flag_cnt, 6);
    chk("t6_fast_data", bus.rx_data, 8'hC3);
    chk("final_errs", err_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
